// File: rtl/div_pkg.sv
// Shared definitions for the HI/LO divide controller: FSM state encoding,
// default datapath width and the settle counter width.
package div_pkg;

    localparam int DIV_WIDTH    = 32;
    localparam int SETTLE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/div_hilo_ctrl_if.sv
// CPU-side request/result bus plus the external divider hookup for div_hilo_ctrl.
// div_zero_exc exists only when DIV_ZERO_TRAP_EN is defined.
interface div_hilo_ctrl_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic               start;
    logic               is_signed;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               mthi;
    logic               mtlo;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH-1:0]   div_dividend;
    logic [WIDTH-1:0]   div_divisor;
    logic [WIDTH-1:0]   div_quotient;
    logic [2*WIDTH-1:0] div_remainder;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
`ifdef DIV_ZERO_TRAP_EN
    logic               div_zero_exc;
`endif

    // master: the pipeline and the external divider; slave: the controller
    modport master (
        output start, is_signed, op_a, op_b, mthi, mtlo, wdata,
        output div_quotient, div_remainder,
        input  div_dividend, div_divisor, busy, done, hi, lo
`ifdef DIV_ZERO_TRAP_EN
        , input div_zero_exc
`endif
    );

    modport slave (
        input  start, is_signed, op_a, op_b, mthi, mtlo, wdata,
        input  div_quotient, div_remainder,
        output div_dividend, div_divisor, busy, done, hi, lo
`ifdef DIV_ZERO_TRAP_EN
        , output div_zero_exc
`endif
    );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; used both to form operand magnitudes
// and to restore result signs. The most negative value maps onto itself.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_out
);

    assign o_out = i_neg ? ('0 - i_in) : i_in;

endmodule

// File: rtl/div_hilo_ctrl.sv
// EX-stage multi-cycle controller for the external unsigned divider, owning HI/LO.
// Optional build macro DIV_ZERO_TRAP_EN: divisor 0 raises div_zero_exc instead of committing.
module div_hilo_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH         = DIV_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input logic             clk,
    input logic             reset,
    div_hilo_ctrl_if.slave  bus
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    state_t                  r_state;
    logic [SETTLE_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]        r_dividend;
    logic [WIDTH-1:0]        r_divisor;
    logic                    r_neg_q;
    logic                    r_neg_r;
    logic                    r_zero;
    logic [WIDTH-1:0]        r_hi;
    logic [WIDTH-1:0]        r_lo;
    logic                    r_busy;
    logic                    r_done;
`ifdef DIV_ZERO_TRAP_EN
    logic                    r_exc;
`else
    logic [WIDTH-1:0]        r_a_raw;
`endif

    logic [WIDTH-1:0] w_op_raw [2];
    logic [WIDTH-1:0] w_op_mag [2];
    logic             w_op_neg [2];
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_unused_rem_hi;

    assign w_op_raw[0] = bus.op_a;
    assign w_op_raw[1] = bus.op_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_mag
        assign w_op_neg[gi] = bus.is_signed & w_op_raw[gi][WIDTH-1];
        div_sign_fix #(.WIDTH(WIDTH)) u_mag (
            .i_in  (w_op_raw[gi]),
            .i_neg (w_op_neg[gi]),
            .o_out (w_op_mag[gi])
        );
    end

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .i_in  (bus.div_quotient),
        .i_neg (r_neg_q),
        .o_out (w_q_fix)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .i_in  (bus.div_remainder[WIDTH-1:0]),
        .i_neg (r_neg_r),
        .o_out (w_r_fix)
    );

    // The divider's remainder port is double width; only the low half is meaningful.
    assign w_unused_rem_hi = ^bus.div_remainder[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_zero     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            r_exc      <= 1'b0;
`else
            r_a_raw    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            r_exc  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dividend <= w_op_mag[0];
                        r_divisor  <= w_op_mag[1];
                        r_neg_q    <= w_op_neg[0] ^ w_op_neg[1];
                        r_neg_r    <= w_op_neg[0];
                        r_zero     <= (bus.op_b == '0);
`ifndef DIV_ZERO_TRAP_EN
                        r_a_raw    <= bus.op_a;
`endif
                        r_cnt      <= SETTLE_LOAD;
                        r_busy     <= 1'b1;
                        r_state    <= SETTLE;
                    end else begin
                        // Register moves only land when no divide is being launched.
                        if (bus.mthi) r_hi <= bus.wdata;
                        if (bus.mtlo) r_lo <= bus.wdata;
                    end
                end
                SETTLE: begin
                    if (r_cnt == '0) r_state <= COMMIT;
                    else             r_cnt   <= r_cnt - SETTLE_CNT_W'(1);
                end
                COMMIT: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (r_zero) begin
`ifdef DIV_ZERO_TRAP_EN
                        r_exc  <= 1'b1;
`else
                        r_hi   <= r_a_raw;
                        r_lo   <= '1;
                        r_done <= 1'b1;
`endif
                    end else begin
                        r_hi   <= w_r_fix;
                        r_lo   <= w_q_fix;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.div_dividend = r_dividend;
    assign bus.div_divisor  = r_divisor;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.hi           = r_hi;
    assign bus.lo           = r_lo;
`ifdef DIV_ZERO_TRAP_EN
    assign bus.div_zero_exc = r_exc;
`endif

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl: vector table of divides plus hand sequences
// for divide-by-zero, ignored requests, register moves and mid-operation reset.
module tb_div_hilo_ctrl;

    localparam int W  = 32;
    localparam int SC = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    div_hilo_ctrl_if #(.WIDTH(W)) bus ();

    div_hilo_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the external unsigned divider; junk in the unused upper half.
    assign bus.div_quotient  = (bus.div_divisor == '0) ? '0 : bus.div_dividend / bus.div_divisor;
    assign bus.div_remainder = {32'hDEAD_BEEF,
                                (bus.div_divisor == '0) ? 32'h0 : bus.div_dividend % bus.div_divisor};

    typedef struct {
        bit         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_lo;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_dvd;
        logic [W-1:0] exp_dvs;
    } vec_t;

    vec_t vecs [7];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit exc_now();
`ifdef DIV_ZERO_TRAP_EN
        return bus.div_zero_exc === 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; launches a divide and waits (bounded) for done or exception.
    task automatic run_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output int busy_n, output bit saw_done,
                           output bit saw_exc, output logic [W-1:0] dvd, output logic [W-1:0] dvs);
        bus.start = 1'b1; bus.is_signed = sgn; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        lat = -1; busy_n = 0; saw_done = 1'b0; saw_exc = 1'b0; dvd = 'x; dvs = 'x;
        for (int k = 0; k < 20; k++) begin
            if (k == 1) begin
                dvd = bus.div_dividend;
                dvs = bus.div_divisor;
            end
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) saw_done = 1'b1;
            if (exc_now()) saw_exc = 1'b1;
            if (saw_done || saw_exc) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        $display("txn div sgn=%0d a=%h b=%h lat=%0d busy=%0d done=%0d exc=%0d hi=%h lo=%h",
                 sgn, a, b, lat, busy_n, saw_done, saw_exc, bus.hi, bus.lo);
    endtask

    initial begin
        int lat, busy_n, cnt;
        bit saw_done, saw_exc;
        logic [W-1:0] dvd, dvs, prev_hi, prev_lo;

        vecs[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         32'd100,       32'd7};
        vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'd7,         32'd2};
        vecs[2] = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,         32'd7,         32'd2};
        vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,         32'h80000000, 32'd1};
        vecs[4] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,         32'h80000000, 32'h80000000, 32'hFFFFFFFF};
        vecs[5] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE, 32'd100,       32'd7};
        vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'h10,        32'h0FFFFFFF, 32'hF,         32'hFFFFFFFF, 32'h10};

        bus.start = 0; bus.is_signed = 0; bus.op_a = 0; bus.op_b = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("txn reset hi=%h lo=%h busy=%0d done=%0d", bus.hi, bus.lo, bus.busy, bus.done);
        chk("rst_hi",   bus.hi, 0);
        chk("rst_lo",   bus.lo, 0);
        chk("rst_busy", W'(bus.busy), 0);
        chk("rst_done", W'(bus.done), 0);
        chk("rst_dvd",  bus.div_dividend, 0);
        chk("rst_dvs",  bus.div_divisor, 0);
`ifdef DIV_ZERO_TRAP_EN
        chk("rst_exc",  W'(bus.div_zero_exc), 0);
`endif

        // Consecutive calls start in the done cycle, so this also covers back-to-back issue.
        for (int i = 0; i < 7; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, busy_n, saw_done, saw_exc, dvd, dvs);
            chk($sformatf("v%0d_lat", i),  W'(lat), SC + 1);
            chk($sformatf("v%0d_busy", i), W'(busy_n), SC + 1);
            chk($sformatf("v%0d_done", i), W'(saw_done), 1);
            chk($sformatf("v%0d_exc", i),  W'(saw_exc), 0);
            chk($sformatf("v%0d_lo", i),   bus.lo, vecs[i].exp_lo);
            chk($sformatf("v%0d_hi", i),   bus.hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_dvd", i),  dvd, vecs[i].exp_dvd);
            chk($sformatf("v%0d_dvs", i),  dvs, vecs[i].exp_dvs);
        end

        // Divide by zero, unsigned then signed-negative dividend.
        prev_hi = vecs[6].exp_hi;
        prev_lo = vecs[6].exp_lo;
        run_div(1'b0, 32'h1234, 32'h0, lat, busy_n, saw_done, saw_exc, dvd, dvs);
        chk("z0_lat", W'(lat), SC + 1);
`ifdef DIV_ZERO_TRAP_EN
        chk("z0_exc",  W'(saw_exc), 1);
        chk("z0_done", W'(saw_done), 0);
        chk("z0_hi",   bus.hi, prev_hi);
        chk("z0_lo",   bus.lo, prev_lo);
        @(negedge clk);
        chk("z0_exc_pulse", W'(bus.div_zero_exc), 0);
        chk("z0_no_done",   W'(bus.done), 0);
`else
        chk("z0_done", W'(saw_done), 1);
        chk("z0_hi",   bus.hi, 32'h1234);
        chk("z0_lo",   bus.lo, 32'hFFFFFFFF);
        @(negedge clk);
        chk("z0_done_pulse", W'(bus.done), 0);
        prev_hi = 32'h1234;
        prev_lo = 32'hFFFFFFFF;
`endif
        run_div(1'b1, 32'hFFFFFF00, 32'h0, lat, busy_n, saw_done, saw_exc, dvd, dvs);
        chk("z1_lat", W'(lat), SC + 1);
`ifdef DIV_ZERO_TRAP_EN
        chk("z1_exc", W'(saw_exc), 1);
        chk("z1_hi",  bus.hi, prev_hi);
        chk("z1_lo",  bus.lo, prev_lo);
`else
        chk("z1_hi",  bus.hi, 32'hFFFFFF00);
        chk("z1_lo",  bus.lo, 32'hFFFFFFFF);
`endif
        @(negedge clk);

        // start and mthi while busy are both dropped.
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 32'd50; bus.op_b = 32'd5; bus.mthi = 1'b1; bus.wdata = 32'hAA;
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0;
        lat = -1;
        for (int k = 2; k < 20; k++) begin
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        $display("txn busy_ignore lat=%0d hi=%h lo=%h", lat, bus.hi, bus.lo);
        chk("ign_lat", W'(lat), SC + 1);
        chk("ign_lo",  bus.lo, 32'd14);
        chk("ign_hi",  bus.hi, 32'd2);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) cnt++;
        end
        chk("ign_no_second", W'(cnt), 0);

        // Register moves in IDLE.
        bus.mtlo = 1'b1; bus.wdata = 32'h55;
        @(negedge clk);
        bus.mtlo = 1'b0;
        $display("txn mtlo wdata=55 hi=%h lo=%h", bus.hi, bus.lo);
        chk("mtlo_lo", bus.lo, 32'h55);
        chk("mtlo_hi", bus.hi, 32'd2);
        bus.mthi = 1'b1; bus.wdata = 32'h12;
        @(negedge clk);
        bus.mthi = 1'b0;
        $display("txn mthi wdata=12 hi=%h lo=%h", bus.hi, bus.lo);
        chk("mthi_hi", bus.hi, 32'h12);
        chk("mthi_lo", bus.lo, 32'h55);

        // start coinciding with mthi: the divide wins, the write is lost.
        bus.mthi = 1'b1; bus.wdata = 32'h77;
        run_div(1'b0, 32'd9, 32'd2, lat, busy_n, saw_done, saw_exc, dvd, dvs);
        chk("coin_lat", W'(lat), SC + 1);
        chk("coin_hi",  bus.hi, 32'd1);
        chk("coin_lo",  bus.lo, 32'd4);
        @(negedge clk);

        // Reset during the second settle cycle aborts cleanly.
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("txn mid_reset busy=%0d done=%0d hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
        chk("mrst_busy", W'(bus.busy), 0);
        chk("mrst_done", W'(bus.done), 0);
        chk("mrst_hi",   bus.hi, 0);
        chk("mrst_lo",   bus.lo, 0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) cnt++;
        end
        chk("mrst_no_done", W'(cnt), 0);
        run_div(1'b0, 32'd100, 32'd7, lat, busy_n, saw_done, saw_exc, dvd, dvs);
        chk("post_lat",  W'(lat), SC + 1);
        chk("post_busy", W'(busy_n), SC + 1);
        chk("post_lo",   bus.lo, 32'd14);
        chk("post_hi",   bus.hi, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
